// File: rtl/aurora_pkt_pkg.sv
// Aurora packet layout shared by the TX arbiter and its neighbours:
// header field offsets, packet/header types, BS_ID constants and the stamping helper.
package aurora_pkt_pkg;

    localparam int PKT_W          = 256;
    localparam int BS_ID_MSB      = 255;
    localparam int BS_ID_LSB      = 248;
    localparam int FPGA_ID_MSB    = 247;
    localparam int FPGA_ID_LSB    = 240;
    localparam int PCKG_ID_MSB    = 239;
    localparam int PCKG_ID_LSB    = 224;
    localparam int TX_UID_MSB     = 223;
    localparam int TX_UID_LSB     = 216;
    localparam int RX_UID_MSB     = 215;
    localparam int RX_UID_LSB     = 208;
    localparam int VPB_MSB        = 207;
    localparam int VPB_LSB        = 192;
    localparam int MSG_W          = 192;

    localparam logic [7:0] BS_ID_XMULT_0   = 8'h00;
    localparam logic [7:0] BS_ID_XMULT_1   = 8'h01;
    localparam logic [7:0] BS_ID_AURORA_0  = 8'h03;
    localparam logic [7:0] BS_ID_BROADCAST = 8'hFF;

    typedef logic [PKT_W-1:0] aurora_pkt_t;

    typedef struct packed {
        logic [7:0]       bs_id;
        logic [7:0]       fpga_id;
        logic [15:0]      pckg_id;
        logic [7:0]       tx_uid;
        logic [7:0]       rx_uid;
        logic [15:0]      valid_bytes;
        logic [MSG_W-1:0] msgs;
    } aurora_hdr_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Replace only FPGA_ID and PCKG_ID; every other bit travels unchanged.
    function automatic aurora_pkt_t stamp_pkt(input aurora_pkt_t pkt,
                                              input logic [7:0]  fpga_id,
                                              input logic [15:0] pckg_id);
        aurora_hdr_t hdr;
        hdr         = pkt;
        hdr.fpga_id = fpga_id;
        hdr.pckg_id = pckg_id;
        return hdr;
    endfunction

endpackage

// File: rtl/aurora_tx_arbiter_rr_select.sv
// Round-robin search: first set bit of valid at or after ptr, wrapping modulo NUM_REQ.
module rr_select #(
    parameter  int NUM_REQ = 3,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               found
);

    logic [IW-1:0] cand_s;

    // Walk offsets from farthest to nearest so the nearest hit is the last assignment.
    always_comb begin
        idx    = {IW{1'b0}};
        found  = 1'b0;
        cand_s = {IW{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = IW'((int'(ptr) + k) % NUM_REQ);
            idx    = valid[cand_s] ? cand_s : idx;
            found  = found | valid[cand_s];
        end
    end

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Round-robin arbiter feeding the 256-bit Aurora TX FIFO; stamps FPGA_ID and PCKG_ID.
// Optional per-requester statistics are enabled with `define AURORA_TX_ARB_STATS_EN.
module aurora_tx_arbiter
    import aurora_pkt_pkg::*;
#(
    parameter  int         NUM_REQ       = 3,
    parameter  int         MAX_BURST     = 4,
    parameter  logic [7:0] LOCAL_FPGA_ID = 8'h00,
    localparam int         IW            = $clog2(NUM_REQ)
) (
    input  logic                      clk_200MHz,
    input  logic                      peripheral_aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0][255:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [255:0]              din,
    output logic                      wr_en,
    input  logic                      full,
    output logic [IW-1:0]             grant_id,
    output logic [15:0]               pckg_id
`ifdef AURORA_TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]  pkt_count,
    output logic [31:0]               stall_cycles
`endif
);

    arb_state_t    state_r, state_nxt_s;
    logic [IW-1:0] grant_r, grant_nxt_s;
    logic [IW-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [3:0]    burst_cnt_r, burst_cnt_nxt_s;
    logic [IW-1:0] sel_idx_s;
    logic          sel_found_s;
    logic          gnt_valid_s;
    logic          accept_s;
    logic [15:0]   pckg_id_r;
    aurora_pkt_t   din_r;
    logic          wr_en_r;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (i == IW'(NUM_REQ - 1)) begin
            return {IW{1'b0}};
        end else begin
            return i + IW'(1);
        end
    endfunction

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .idx   (sel_idx_s),
        .found (sel_found_s)
    );

    assign gnt_valid_s = req_valid[grant_r];
    assign accept_s    = (state_r == ST_BURST) && gnt_valid_s && !full;

    // Only the grant holder sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (accept_s) begin
            req_ready[grant_r] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Next-state logic; a full stall holds grant and burst count without rotating.
    always_comb begin
        state_nxt_s     = state_r;
        grant_nxt_s     = grant_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        burst_cnt_nxt_s = burst_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    grant_nxt_s     = sel_idx_s;
                    burst_cnt_nxt_s = 4'd0;
                    state_nxt_s     = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!gnt_valid_s) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = wrap_inc(grant_r);
                end else if (accept_s) begin
                    burst_cnt_nxt_s = burst_cnt_r + 4'd1;
                    if (burst_cnt_r == 4'(MAX_BURST - 1)) begin
                        state_nxt_s  = ST_IDLE;
                        rr_ptr_nxt_s = wrap_inc(grant_r);
                    end else begin
                        state_nxt_s = ST_BURST;
                    end
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM and arbitration registers.
    always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state_r     <= ST_IDLE;
            grant_r     <= {IW{1'b0}};
            rr_ptr_r    <= {IW{1'b0}};
            burst_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Write path: din holds the last stamped packet between writes.
    always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            din_r     <= {PKT_W{1'b0}};
            wr_en_r   <= 1'b0;
            pckg_id_r <= 16'd0;
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                din_r     <= stamp_pkt(req_data[grant_r], LOCAL_FPGA_ID, pckg_id_r);
                pckg_id_r <= pckg_id_r + 16'd1;
            end
        end
    end

    assign din      = din_r;
    assign wr_en    = wr_en_r;
    assign grant_id = grant_r;
    assign pckg_id  = pckg_id_r;

`ifdef AURORA_TX_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] pkt_cnt_r;
    logic [31:0]              stall_cnt_r;

    // Saturating per-requester accept counters and FIFO-backpressure cycle counter.
    always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            pkt_cnt_r   <= {NUM_REQ{32'd0}};
            stall_cnt_r <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept_s && (grant_r == IW'(i)) && (pkt_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    pkt_cnt_r[i] <= pkt_cnt_r[i] + 32'd1;
                end
            end
            if ((state_r == ST_BURST) && gnt_valid_s && full && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign pkt_count    = pkt_cnt_r;
    assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed bench for aurora_tx_arbiter: three instances (MAX_BURST 4, 1 and 15) share one clock.
`timescale 1ns/1ps
module tb_aurora_tx_arbiter;

    logic                clk_200MHz;
    logic                rstn [3];
    logic [2:0]          rv   [3];
    logic [2:0][255:0]   rd   [3];
    logic [2:0]          rr   [3];
    logic [255:0]        dn   [3];
    logic                we   [3];
    logic                fl   [3];
    logic [1:0]          gid  [3];
    logic [15:0]         pid  [3];
`ifdef AURORA_TX_ARB_STATS_EN
    logic [2:0][31:0]    pc   [3];
    logic [31:0]         stl  [3];
`endif

    int left [3][3];
    int sq   [3][3];
    int n_tests = 0;
    int n_fail  = 0;

    aurora_tx_arbiter #(.NUM_REQ(3), .MAX_BURST(4), .LOCAL_FPGA_ID(8'h00)) dut_a (
        .clk_200MHz(clk_200MHz), .peripheral_aresetn(rstn[0]), .req_valid(rv[0]), .req_data(rd[0]),
        .req_ready(rr[0]), .din(dn[0]), .wr_en(we[0]), .full(fl[0]), .grant_id(gid[0]), .pckg_id(pid[0])
`ifdef AURORA_TX_ARB_STATS_EN
        , .pkt_count(pc[0]), .stall_cycles(stl[0])
`endif
    );

    aurora_tx_arbiter #(.NUM_REQ(3), .MAX_BURST(1), .LOCAL_FPGA_ID(8'h5A)) dut_b (
        .clk_200MHz(clk_200MHz), .peripheral_aresetn(rstn[1]), .req_valid(rv[1]), .req_data(rd[1]),
        .req_ready(rr[1]), .din(dn[1]), .wr_en(we[1]), .full(fl[1]), .grant_id(gid[1]), .pckg_id(pid[1])
`ifdef AURORA_TX_ARB_STATS_EN
        , .pkt_count(pc[1]), .stall_cycles(stl[1])
`endif
    );

    aurora_tx_arbiter #(.NUM_REQ(3), .MAX_BURST(15), .LOCAL_FPGA_ID(8'h3C)) dut_w (
        .clk_200MHz(clk_200MHz), .peripheral_aresetn(rstn[2]), .req_valid(rv[2]), .req_data(rd[2]),
        .req_ready(rr[2]), .din(dn[2]), .wr_en(we[2]), .full(fl[2]), .grant_id(gid[2]), .pckg_id(pid[2])
`ifdef AURORA_TX_ARB_STATS_EN
        , .pkt_count(pc[2]), .stall_cycles(stl[2])
`endif
    );

    initial begin
        clk_200MHz = 1'b0;
        forever #2.5 clk_200MHz = ~clk_200MHz;
    end

    // Raw packet from requester src of instance d, sequence s; FPGA_ID/PCKG_ID hold junk to be overwritten.
    function automatic logic [255:0] mk_pkt(input int d, input int src, input int s);
        logic [255:0] p;
        logic [31:0]  m;
        m          = 32'(s) ^ 32'hDEAD_0000 ^ (32'(src) << 8);
        p[255:248] = 8'(src);
        p[247:240] = 8'hAA;
        p[239:224] = 16'hC3C3;
        p[223:216] = 8'(s);
        p[215:208] = 8'(d);
        p[207:192] = (s % 2 == 1) ? 16'd28 : 16'd24;
        p[191:0]   = {6{m}};
        return p;
    endfunction

    function automatic logic [255:0] exp_pkt(input logic [255:0] p, input logic [7:0] f, input logic [15:0] id);
        logic [255:0] q;
        q            = p;
        q[247:240]   = f;
        q[239:224]   = id;
        return q;
    endfunction

    task automatic load(input int d, input int i, input int n);
        left[d][i] = n;
        sq[d][i]   = 0;
        rd[d][i]   = mk_pkt(d, i, 0);
        rv[d][i]   = (n > 0);
    endtask

    // One clock: requesters that were accepted before the edge present their next packet.
    task automatic step();
        logic acc [3][3];
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 3; i++)
                acc[d][i] = rr[d][i] & rv[d][i];
        @(posedge clk_200MHz);
        #1;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 3; i++)
                if (acc[d][i]) begin
                    sq[d][i]   = sq[d][i] + 1;
                    left[d][i] = left[d][i] - 1;
                    if (left[d][i] > 0) rd[d][i] = mk_pkt(d, i, sq[d][i]);
                    else rv[d][i] = 1'b0;
                end
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0; fl[d] = 1'b0; rv[d] = 3'b000; rd[d] = '0;
            for (int i = 0; i < 3; i++) begin left[d][i] = 0; sq[d][i] = 0; end
        end
        #3;
        for (int d = 0; d < 3; d++) begin
            n_tests++; if (we[d] !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en[%0d]: got %b exp 0", d, we[d]); end
            n_tests++; if (dn[d] !== 256'd0) begin n_fail++; $display("FAIL reset_din[%0d]: got %h exp 0", d, dn[d]); end
            n_tests++; if (rr[d] !== 3'b000) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b exp 000", d, rr[d]); end
            n_tests++; if (gid[d] !== 2'd0) begin n_fail++; $display("FAIL reset_grant[%0d]: got %0d exp 0", d, gid[d]); end
            n_tests++; if (pid[d] !== 16'd0) begin n_fail++; $display("FAIL reset_pckg_id[%0d]: got %h exp 0", d, pid[d]); end
        end
        step(); step();
        for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
        step();
    endtask

    task automatic test_single_burst();
        logic [7:0] pat;
        int         n;
        pat = 8'b1111_0110;
        n   = 0;
        load(0, 0, 6);
        #1;
        n_tests++; if (rr[0] !== 3'b000) begin n_fail++; $display("FAIL burst_idle_ready: got %b exp 000", rr[0]); end
        step();
        n_tests++; if (rr[0] !== 3'b001) begin n_fail++; $display("FAIL burst_ready: got %b exp 001", rr[0]); end
        n_tests++; if (we[0] !== 1'b0) begin n_fail++; $display("FAIL burst_idle_wr: got %b exp 0", we[0]); end
        for (int k = 0; k < 8; k++) begin
            step();
            n_tests++;
            if (we[0] !== pat[7-k]) begin
                n_fail++; $display("FAIL burst_wr_en cyc%0d: got %b exp %b", k, we[0], pat[7-k]);
            end else if (pat[7-k]) begin
                n_tests++;
                if (dn[0] !== exp_pkt(mk_pkt(0, 0, n), 8'h00, 16'(n))) begin
                    n_fail++; $display("FAIL burst_din pkt%0d: got %h exp %h", n, dn[0], exp_pkt(mk_pkt(0, 0, n), 8'h00, 16'(n)));
                end
                n++;
            end
        end
        n_tests++; if (pid[0] !== 16'd6) begin n_fail++; $display("FAIL burst_pckg_id: got %0d exp 6", pid[0]); end
    endtask

    task automatic test_stall();
        load(0, 1, 4);
        step();
        n_tests++; if (gid[0] !== 2'd1) begin n_fail++; $display("FAIL stall_grant: got %0d exp 1", gid[0]); end
        n_tests++; if (rr[0] !== 3'b010) begin n_fail++; $display("FAIL stall_ready: got %b exp 010", rr[0]); end
        step();
        n_tests++; if (dn[0] !== exp_pkt(mk_pkt(0, 1, 0), 8'h00, 16'd6) || we[0] !== 1'b1) begin
            n_fail++; $display("FAIL stall_first: got we=%b %h exp we=1 %h", we[0], dn[0], exp_pkt(mk_pkt(0, 1, 0), 8'h00, 16'd6));
        end
        fl[0] = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (rr[0] !== 3'b000) begin n_fail++; $display("FAIL stall_ready_low cyc%0d: got %b exp 000", k, rr[0]); end
            step();
            n_tests++; if (we[0] !== 1'b0) begin n_fail++; $display("FAIL stall_wr_en cyc%0d: got %b exp 0", k, we[0]); end
            n_tests++; if (gid[0] !== 2'd1) begin n_fail++; $display("FAIL stall_grant_hold cyc%0d: got %0d exp 1", k, gid[0]); end
        end
        fl[0] = 1'b0;
        #1;
        n_tests++; if (rr[0] !== 3'b010) begin n_fail++; $display("FAIL stall_resume_ready: got %b exp 010", rr[0]); end
        for (int k = 1; k < 4; k++) begin
            step();
            n_tests++;
            if (we[0] !== 1'b1 || dn[0] !== exp_pkt(mk_pkt(0, 1, k), 8'h00, 16'(6 + k))) begin
                n_fail++; $display("FAIL stall_resume pkt%0d: got we=%b %h exp %h", k, we[0], dn[0], exp_pkt(mk_pkt(0, 1, k), 8'h00, 16'(6 + k)));
            end
        end
        step();
        n_tests++; if (we[0] !== 1'b0) begin n_fail++; $display("FAIL stall_end_wr: got %b exp 0", we[0]); end
        n_tests++; if (pid[0] !== 16'd10) begin n_fail++; $display("FAIL stall_pckg_id: got %0d exp 10", pid[0]); end
    endtask

    task automatic test_reset_mid_burst();
        load(0, 2, 3);
        step(); step(); step();
        n_tests++; if (we[0] !== 1'b1 || dn[0][239:224] !== 16'd11) begin
            n_fail++; $display("FAIL mid_pre: got we=%b id=%h exp we=1 id=000b", we[0], dn[0][239:224]);
        end
        rstn[0] = 1'b0;
        #1;
        n_tests++; if (we[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_en: got %b exp 0", we[0]); end
        n_tests++; if (dn[0] !== 256'd0) begin n_fail++; $display("FAIL mid_rst_din: got %h exp 0", dn[0]); end
        n_tests++; if (rr[0] !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ready: got %b exp 000", rr[0]); end
        n_tests++; if (gid[0] !== 2'd0) begin n_fail++; $display("FAIL mid_rst_grant: got %0d exp 0", gid[0]); end
        n_tests++; if (pid[0] !== 16'd0) begin n_fail++; $display("FAIL mid_rst_pckg_id: got %h exp 0", pid[0]); end
        step(); step();
        load(0, 0, 2);
        rstn[0] = 1'b1;
        step();
        n_tests++; if (gid[0] !== 2'd0) begin n_fail++; $display("FAIL mid_regrant: got %0d exp 0", gid[0]); end
        step();
        n_tests++; if (we[0] !== 1'b1 || dn[0] !== exp_pkt(mk_pkt(0, 0, 0), 8'h00, 16'd0)) begin
            n_fail++; $display("FAIL mid_first_pkt: got we=%b %h exp %h", we[0], dn[0], exp_pkt(mk_pkt(0, 0, 0), 8'h00, 16'd0));
        end
        n_tests++; if (pid[0] !== 16'd1) begin n_fail++; $display("FAIL mid_pckg_id: got %0d exp 1", pid[0]); end
        rv[0] = 3'b000;
        for (int i = 0; i < 3; i++) left[0][i] = 0;
        step(); step(); step();
    endtask

    task automatic test_rotation();
        int src;
        for (int i = 0; i < 3; i++) load(1, i, 4);
        step();
        n_tests++; if (gid[1] !== 2'd0) begin n_fail++; $display("FAIL rot_first_grant: got %0d exp 0", gid[1]); end
        for (int k = 0; k < 12; k++) begin
            step();
            n_tests++;
            if (k % 2 == 0) begin
                src = (k / 2) % 3;
                if (we[1] !== 1'b1 || dn[1] !== exp_pkt(mk_pkt(1, src, (k / 2) / 3), 8'h5A, 16'(k / 2))) begin
                    n_fail++; $display("FAIL rot_write cyc%0d: got we=%b %h exp src%0d %h", k, we[1], dn[1], src,
                                       exp_pkt(mk_pkt(1, src, (k / 2) / 3), 8'h5A, 16'(k / 2)));
                end
            end else begin
                if (we[1] !== 1'b0 || gid[1] !== 2'(((k + 1) / 2) % 3)) begin
                    n_fail++; $display("FAIL rot_gap cyc%0d: got we=%b grant=%0d exp we=0 grant=%0d", k, we[1], gid[1], ((k + 1) / 2) % 3);
                end
            end
        end
        rv[1] = 3'b000;
        for (int i = 0; i < 3; i++) left[1][i] = 0;
        step(); step();
    endtask

    task automatic test_pckg_wrap();
        int          cyc;
        int          got;
        logic [15:0] exp_id [3];
        exp_id[0] = 16'hFFFE; exp_id[1] = 16'hFFFF; exp_id[2] = 16'h0000;
        load(2, 0, 70000);
        cyc = 0;
        while (pid[2] !== 16'hFFFE && cyc < 80000) begin step(); cyc++; end
        n_tests++; if (pid[2] !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload: got %h exp fffe after %0d cycles", pid[2], cyc); end
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 20) begin
            step(); cyc++;
            if (we[2] === 1'b1) begin
                n_tests++;
                if (dn[2][239:224] !== exp_id[got] || dn[2][247:240] !== 8'h3C) begin
                    n_fail++; $display("FAIL wrap_stamp%0d: got id=%h fpga=%h exp id=%h fpga=3c", got, dn[2][239:224], dn[2][247:240], exp_id[got]);
                end
                got++;
            end
        end
        n_tests++; if (got != 3) begin n_fail++; $display("FAIL wrap_timeout: got %0d writes exp 3", got); end
        rv[2] = 3'b000;
        left[2][0] = 0;
        step(); step();
    endtask

    task automatic test_stats();
`ifdef AURORA_TX_ARB_STATS_EN
        rstn[0] = 1'b0;
        step();
        rstn[0] = 1'b1;
        step();
        load(0, 2, 3);
        step();
        n_tests++; if (gid[0] !== 2'd2) begin n_fail++; $display("FAIL stats_grant: got %0d exp 2", gid[0]); end
        fl[0] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        fl[0] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_tests++; if (pc[0][2] !== 32'd3) begin n_fail++; $display("FAIL stats_pkt_count2: got %0d exp 3", pc[0][2]); end
        n_tests++; if (pc[0][0] !== 32'd0) begin n_fail++; $display("FAIL stats_pkt_count0: got %0d exp 0", pc[0][0]); end
        n_tests++; if (stl[0] !== 32'd4) begin n_fail++; $display("FAIL stats_stall: got %0d exp 4", stl[0]); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_stall();
        test_reset_mid_burst();
        test_rotation();
        test_pckg_wrap();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
